// File: rtl/mul_ser_arb.sv
// Round-robin arbiter/sequencer sharing one serial multiplier among N_REQ requesters.
// Optional WAIT timeout with error response: define MUL_TIMEOUT_EN.
module mul_ser_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_x,
    input  logic [8*N_REQ-1:0]   req_a,
    output logic [N_REQ-1:0]     gnt,
    output logic                 mul_start,
    output logic [7:0]           mul_x,
    output logic [7:0]           mul_a,
    input  logic                 mul_done,
    input  logic [15:0]          mul_y,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_y,
`ifdef MUL_TIMEOUT_EN
    output logic                 rsp_err,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    if (N_REQ != (1 << ID_W) || N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("mul_ser_arb: unsupported parameter combination");
    end

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   cur_id_q;
    logic [N_REQ-1:0]  gnt_q;
    logic              mul_start_q;
    logic [7:0]        mul_x_q;
    logic [7:0]        mul_a_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [15:0]       rsp_y_q;
    logic              busy_q;
    logic              found_d;
    logic [ID_W-1:0]   win_d;
    logic [ID_W-1:0]   idx_d;

`ifdef MUL_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              rsp_err_q;
`endif

    // Rotating-priority search starting at rr_ptr; N_REQ is a power of two so ID_W truncation wraps.
    always_comb begin
        found_d = 1'b0;
        win_d   = rr_ptr_q;
        idx_d   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_d = rr_ptr_q + ID_W'(k);
            if (!found_d && req[idx_d]) begin
                found_d = 1'b1;
                win_d   = idx_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cur_id_q    <= '0;
            gnt_q       <= '0;
            mul_start_q <= 1'b0;
            mul_x_q     <= '0;
            mul_a_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            busy_q      <= 1'b0;
`ifdef MUL_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            gnt_q       <= '0;
            mul_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gnt_q    <= N_REQ'(1) << win_d;
                        mul_x_q  <= req_x[8*win_d +: 8];
                        mul_a_q  <= req_a[8*win_d +: 8];
                        cur_id_q <= win_d;
                        busy_q   <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_start_q <= 1'b1;
                    state_q     <= S_WAIT;
`ifdef MUL_TIMEOUT_EN
                    wait_cnt_q  <= '0;
`endif
                end
                S_WAIT: begin
                    // The start cycle is already WAIT here; a done coinciding with start is ignored.
                    if (mul_done && !mul_start_q) begin
                        rsp_y_q     <= mul_y;
                        rsp_id_q    <= cur_id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
`ifdef MUL_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_y_q     <= 16'h8000;
                        rsp_id_q    <= cur_id_q;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    rr_ptr_q  <= cur_id_q + ID_W'(1);
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
`ifdef MUL_TIMEOUT_EN
                    rsp_err_q <= 1'b0;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign mul_start = mul_start_q;
    assign mul_x     = mul_x_q;
    assign mul_a     = mul_a_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign busy      = busy_q;
`ifdef MUL_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`endif

endmodule
